databus_master: RTL
===================

// Module: databus_master
// PURPOSE
//  Bus initiator for the 16x8 register databus (R0/R1 = ALU operands, R2 = ALU result, R13-R15 = ALU flags).
//  - Accepts single register transactions from a control sequencer over a valid/ready request channel.
//  - Drives the databus addr / rd_wr / datain lines and samples its combinational dataout.
//  - Returns results over a valid/ready response channel.
//  - Supports write, read and register-to-register move; one transaction in flight.
// PARAMETERS
//  ADDR_W     4  databus address width (16 registers)
//  DATA_W     8  databus data width
//  READ_WAIT  0  extra cycles bus_addr is held before dataout is sampled (0..15)
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  rst          in   1       synchronous active-high reset
//  req_valid    in   1       request present
//  req_ready    out  1       request accepted when req_valid && req_ready
//  req_op       in   2       00 write, 01 read, 10 move, 11 reserved
//  req_addr     in   ADDR_W  write/read target; move source
//  req_addr2    in   ADDR_W  move destination (ignored otherwise)
//  req_data     in   DATA_W  write data (ignored otherwise)
//  rsp_valid    out  1       response present
//  rsp_ready    in   1       response consumed when rsp_valid && rsp_ready
//  rsp_data     out  DATA_W  read/moved value; write echoes req_data; 0 on error
//  rsp_err      out  1       1 = reserved op was rejected
//  bus_addr     out  ADDR_W  to databus addr
//  bus_rd_wr    out  1       to databus rd_wr (1 = write this edge)
//  bus_datain   out  DATA_W  to databus datain
//  bus_dataout  in   DATA_W  from databus dataout (combinational on bus_addr)
//  busy         out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 (req_ready rises the cycle after rst drops); wait counter 0.
//  Reset mid-transaction aborts it: no response; bus_rd_wr is 0 from the first cycle rst is high.
//  States and transitions:
//  - IDLE: req_ready=1; bus_rd_wr=0, bus_addr=0, bus_datain=0. On handshake, latch op/addr/addr2/data.
//      op00 -> WR; op01 and op10 -> RD (counter=READ_WAIT); op11 -> RESP with err=1.
//  - WR: bus_addr=addr, bus_datain=data, bus_rd_wr=1 for exactly one cycle; rsp_data<=data; -> RESP.
//  - RD: bus_addr=addr, bus_rd_wr=0. Counter>0: decrement and stay.
//      Counter==0: rsp_data<=bus_dataout; op01 -> RESP, op10 -> MV_WR.
//  - MV_WR: bus_addr=addr2, bus_datain=captured value, bus_rd_wr=1 for one cycle; -> RESP.
//  - RESP: rsp_valid=1; rsp_data/rsp_err stable until rsp_ready. On handshake -> IDLE; rsp_valid=0 next cycle.
//  Latency, accept edge = T: rsp_valid rises at T+2 for write and error, T+2+READ_WAIT for read, T+3+READ_WAIT for move.
//  req_ready=0 outside IDLE, so there is no back-to-back accept. Minimum spacing is one IDLE cycle after the response handshake.
//  Move with addr==addr2 is legal and rewrites the same value.
//  Request fields are don't-care outside the accept cycle.
//  A rsp_ready stall holds RESP indefinitely with no bus activity (bus_rd_wr=0).
//  bus_rd_wr is never high in IDLE, RD or RESP, and at most one write is issued per transaction.
// TESTING
//  - Reset: rst high 2 cycles mid-move (in RD) -> no rsp_valid, bus_rd_wr=0 throughout, destination register unchanged.
//  - Write 0xA5 to addr 3 -> bus_rd_wr=1 at T+1 only; rsp_valid at T+2 with rsp_data=0xA5, rsp_err=0.
//      A following read of addr 3 returns 0xA5.
//  - READ_WAIT=2, read addr 13 after writing 0x01 -> bus_addr=13 held 3 cycles; rsp_data=0x01 at T+4.
//  - Move addr 2 -> addr 7, with R2=0x3C -> one write to 7 with datain 0x3C; rsp_data=0x3C; a read of 7 returns 0x3C.
//  - op=11 -> rsp_err=1, rsp_data=0 at T+2, no bus write.
//      Hold rsp_ready=0 for 5 cycles -> outputs stable, req_ready=0.

Source files
------------

// File: rtl/databus_master.sv
// databus_master: single-transaction initiator for the 16x8 register databus.
// Takes write / read / move requests over a valid/ready channel, drives the
// databus addr / rd_wr / datain lines, samples the combinational dataout and
// returns the result over a valid/ready response channel.
module databus_master #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int READ_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_addr2,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rd_wr,
  output logic [DATA_W-1:0] bus_datain,
  input  logic [DATA_W-1:0] bus_dataout,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_MV_WR,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_READ   = 2'b01;
  localparam logic [1:0] OP_MOVE   = 2'b10;
  localparam logic [3:0] WAIT_INIT = 4'(READ_WAIT);

  state_t              state;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   addr2_q;
  logic [DATA_W-1:0]   data_q;
  logic [3:0]          wait_cnt;
  logic                wr_q;

  // NOTE: the write strobe is masked by rst so a reset aborts a pending write
  // in the very cycle rst rises, not one edge later when the register clears.
  assign bus_rd_wr = wr_q & ~rst;

  // Transaction FSM; every output except the masked write strobe is registered.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every branch sees
    // the pre-edge values of state, wait_cnt and the response registers.
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= OP_WRITE;
      addr2_q    <= '0;
      data_q     <= '0;
      wait_cnt   <= '0;
      wr_q       <= 1'b0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      bus_addr   <= '0;
      bus_datain <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            op_q      <= req_op;
            addr2_q   <= req_addr2;
            data_q    <= req_data;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            rsp_err   <= 1'b0;
            case (req_op)
              OP_WRITE: begin
                bus_addr   <= req_addr;
                bus_datain <= req_data;
                wr_q       <= 1'b1;
                state      <= S_WR;
              end
              OP_READ, OP_MOVE: begin
                bus_addr <= req_addr;
                wait_cnt <= WAIT_INIT;
                state    <= S_RD;
              end
              default: begin
                // Reserved op: no bus activity; RESP raises rsp_valid one
                // edge later so errors share the write-path latency.
                rsp_err  <= 1'b1;
                rsp_data <= '0;
                state    <= S_RESP;
              end
            endcase
          end else begin
            req_ready <= 1'b1;
          end
        end

        S_WR: begin
          wr_q       <= 1'b0;
          bus_addr   <= '0;
          bus_datain <= '0;
          rsp_data   <= data_q;
          rsp_valid  <= 1'b1;
          state      <= S_RESP;
        end

        S_RD: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            rsp_data <= bus_dataout;
            if (op_q == OP_MOVE) begin
              bus_addr   <= addr2_q;
              bus_datain <= bus_dataout;
              wr_q       <= 1'b1;
              state      <= S_MV_WR;
            end else begin
              bus_addr  <= '0;
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end
          end
        end

        S_MV_WR: begin
          wr_q       <= 1'b0;
          bus_addr   <= '0;
          bus_datain <= '0;
          rsp_valid  <= 1'b1;
          state      <= S_RESP;
        end

        S_RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
